store_buffer: RTL

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/mem_pkg.sv | 20 ++
 rtl/sb_fifo.sv | 57 +++++
 rtl/store_buffer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types for the store buffer: the buffered entry, the drain FSM state
// and the default geometry.
package mem_pkg;

    localparam int SB_DEPTH  = 4;
    localparam int SB_ADDR_W = 9;
    localparam int SB_DATA_W = 32;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
        logic [2:0]           funct3;
    } sb_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FENCE = 1'b1
    } sb_state_t;

endpackage

// File: rtl/sb_fifo.sv
// In-order entry storage for the store buffer: circular array, head/tail
// pointers wrapping modulo DEPTH, per-slot valid bits and a registered count.
module sb_fifo
    import mem_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic                        pop,
    input  sb_entry_t                   wr_entry,
    output sb_entry_t                   head_entry,
    output sb_entry_t [DEPTH-1:0]       entries,
    output logic      [DEPTH-1:0]       valid,
    output logic      [PTR_W:0]         count
);

    sb_entry_t [DEPTH-1:0] mem;
    logic      [PTR_W-1:0] head;
    logic      [PTR_W-1:0] tail;

    assign entries    = mem;
    assign head_entry = mem[head];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            if (pop) begin
                head        <= head + PTR_W'(1);
                valid[head] <= 1'b0;
            end
            if (push) begin
                tail        <= tail + PTR_W'(1);
                valid[tail] <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload carries no reset; the valid bits decide what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= wr_entry;
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between EX/MEM and data memory: queues stores, drains them in
// order when the memory port is free, stalls loads that hit a pending store.
module store_buffer
    import mem_pkg::*;
#(
    parameter int DM_ADDRESS = SB_ADDR_W,
    parameter int DATA_W     = SB_DATA_W,
    parameter int DEPTH      = SB_DEPTH,
    localparam int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [DM_ADDRESS-1:0] a,
    input  logic [DATA_W-1:0]     wd,
    input  logic [2:0]            Funct3,
    input  logic                  fence,
    output logic                  dm_MemRead,
    output logic                  dm_MemWrite,
    output logic [DM_ADDRESS-1:0] dm_a,
    output logic [DATA_W-1:0]     dm_wd,
    output logic [2:0]            dm_Funct3,
    output logic                  stall,
    output logic [CNT_W-1:0]      count,
    output logic                  empty,
    output logic                  full
);

    localparam logic [DM_ADDRESS-1:0] WORD_MASK = ~DM_ADDRESS'(3);

    sb_state_t             state;
    sb_state_t             next_state;
    sb_entry_t             wr_entry;
    sb_entry_t             head_entry;
    sb_entry_t [DEPTH-1:0] entries;
    logic      [DEPTH-1:0] valid;
    logic                  push;
    logic                  pop;
    logic                  load_pass;
    logic                  hit;

    assign wr_entry = '{addr: a, data: wd, funct3: Funct3};
    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));

    sb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .wr_entry   (wr_entry),
        .head_entry (head_entry),
        .entries    (entries),
        .valid      (valid),
        .count      (count)
    );

    // Word-granular hazard: any live store in the same 32-bit word blocks a load.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (((entries[i].addr ^ a) & WORD_MASK) == '0)) begin
                hit = 1'b1;
            end
        end
    end

    always_comb begin
        stall      = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        load_pass  = 1'b0;
        next_state = state;
        if (state == FENCE || (fence && !empty)) begin
            stall      = 1'b1;
            pop        = !empty;
            next_state = (count <= CNT_W'(1)) ? RUN : FENCE;
        end else if (MemRead) begin
            if (hit) begin
                stall = 1'b1;
                pop   = 1'b1;
            end else begin
                load_pass = 1'b1;
            end
        end else begin
            pop = !empty;
            if (MemWrite) begin
                // A full buffer refuses the store even if the head leaves this cycle.
                if (full) begin
                    stall = 1'b1;
                end else begin
                    push = 1'b1;
                end
            end
        end
    end

    always_comb begin
        dm_MemRead  = 1'b0;
        dm_MemWrite = 1'b0;
        dm_a        = '0;
        dm_wd       = '0;
        dm_Funct3   = '0;
        if (pop) begin
            dm_MemWrite = 1'b1;
            dm_a        = head_entry.addr;
            dm_wd       = head_entry.data;
            dm_Funct3   = head_entry.funct3;
        end else if (load_pass) begin
            dm_MemRead = 1'b1;
            dm_a       = a;
            dm_Funct3  = Funct3;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

endmodule
